alu_wb: RTL and testbench

Issue/writeback sequencer wrapped around the 2-cycle registered ALU. It accepts ALU instructions from decode through a valid/ready handshake and forwards the opcode to the ALU. It tracks each op through the ALU's two register stages and writes results to the register file, including the two-byte MULT result. It owns the status register (C, Z, N), drives the ALU carry-in, and enforces the carry and write-port interlocks.

---
 rtl/alu_wb_if.sv | 35 +++
 rtl/alu_wb.sv | 125 ++++++++++++
 tb/tb_alu_wb.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_wb_if.sv
// Issue, ALU and register-file write signals shared between decode, the ALU and alu_wb.
// The master side is the decode/ALU/RF environment; the slave side is alu_wb.
interface alu_wb_if #(
    parameter int RF_AW = 4
);
    logic             issue_valid;
    logic             issue_ready;
    logic [7:0]       issue_opcode;
    logic [RF_AW-1:0] issue_rd;

    logic [7:0]       alu_opcode;
    logic             alu_ci;
    logic [15:0]      alu_data;
    logic             alu_co;
    logic             alu_zo;
    logic             alu_no;

    logic             rf_we;
    logic [RF_AW-1:0] rf_waddr;
    logic [7:0]       rf_wdata;

    modport master (
        output issue_valid, issue_opcode, issue_rd,
        output alu_data, alu_co, alu_zo, alu_no,
        input  issue_ready, alu_opcode, alu_ci,
        input  rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  issue_valid, issue_opcode, issue_rd,
        input  alu_data, alu_co, alu_zo, alu_no,
        output issue_ready, alu_opcode, alu_ci,
        output rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/alu_wb.sv
// Issue/writeback sequencer around the 2-cycle registered ALU: tracks ops, writes results, owns {C,Z,N}.
// Build option ALU_WB_CARRY_FWD_EN: forward alu_co into alu_ci so carry ops stall 1 cycle instead of 2.
module alu_wb #(
    parameter int               RF_AW       = 4,
    parameter logic [RF_AW-1:0] MUL_LO_ADDR = RF_AW'(0),
    parameter logic [RF_AW-1:0] MUL_HI_ADDR = RF_AW'(1),
    parameter logic [7:0]       NOP_OPCODE  = 8'hF0
) (
    input  logic        clk,
    input  logic        rst,
    alu_wb_if.slave     bus,
    output logic [2:0]  sreg,
    output logic        illegal_op,
    output logic        busy
);
    localparam logic [3:0] MUL_NIBBLE = 4'h3;

    function automatic logic op_legal(input logic [7:0] op);
        op_legal = (op[7] == 1'b0)
                || (op[7:4] == 4'b1000)
                || ((op[7:4] == 4'b1001) && (op[1:0] == 2'b00));
    endfunction

    // ADDC, SUBC, ROL, ROR
    function automatic logic op_uses_carry(input logic [7:0] op);
        op_uses_carry = (op[7:4] == 4'b0101)
                     || (op[7:4] == 4'b0111)
                     || ((op[7:4] == 4'b1000) && op[1]);
    endfunction

    function automatic logic op_is_mul(input logic [7:0] op);
        op_is_mul = (op[7:4] == MUL_NIBBLE);
    endfunction

    logic             fire;
    logic             carry_block;

    logic             vld_p1;
    logic             legal_p1;
    logic             mul_p1;
    logic [RF_AW-1:0] rd_p1;

    logic             vld_p2;
    logic             legal_p2;
    logic             mul_p2;
    logic [RF_AW-1:0] rd_p2;

    logic             hi_pend;
    logic [7:0]       hi_q;

    // Issue: handshake, carry interlock and ALU opcode/carry-in
    always_comb begin
`ifdef ALU_WB_CARRY_FWD_EN
        carry_block = vld_p1 && legal_p1;
`else
        carry_block = (vld_p1 && legal_p1) || (vld_p2 && legal_p2);
`endif
        bus.issue_ready = !(vld_p1 && mul_p1)
                       && !(op_uses_carry(bus.issue_opcode) && carry_block);
        fire = bus.issue_valid && bus.issue_ready;
        bus.alu_opcode = fire ? bus.issue_opcode : NOP_OPCODE;
`ifdef ALU_WB_CARRY_FWD_EN
        bus.alu_ci = (vld_p2 && legal_p2) ? bus.alu_co : sreg[2];
`else
        bus.alu_ci = sreg[2];
`endif
    end

    // Stage 1 / stage 2 control tags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            legal_p1 <= 1'b0;
            mul_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            legal_p2 <= 1'b0;
            mul_p2   <= 1'b0;
        end else begin
            vld_p1   <= fire;
            legal_p1 <= fire && op_legal(bus.issue_opcode);
            mul_p1   <= fire && op_is_mul(bus.issue_opcode);
            vld_p2   <= vld_p1;
            legal_p2 <= legal_p1;
            mul_p2   <= mul_p1;
        end
    end

    always_ff @(posedge clk) begin
        rd_p1 <= bus.issue_rd;
        rd_p2 <= rd_p1;
        if (vld_p2 && mul_p2)
            hi_q <= bus.alu_data[15:8];
    end

    // Writeback: stage 2 result or pending MULT high byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
            sreg         <= 3'b000;
            illegal_op   <= 1'b0;
            hi_pend      <= 1'b0;
        end else begin
            bus.rf_we  <= 1'b0;
            illegal_op <= 1'b0;
            hi_pend    <= 1'b0;
            if (hi_pend) begin
                bus.rf_we    <= 1'b1;
                bus.rf_waddr <= MUL_HI_ADDR;
                bus.rf_wdata <= hi_q;
            end else if (vld_p2 && legal_p2) begin
                bus.rf_we    <= 1'b1;
                bus.rf_waddr <= mul_p2 ? MUL_LO_ADDR : rd_p2;
                bus.rf_wdata <= bus.alu_data[7:0];
                sreg         <= {bus.alu_co, bus.alu_zo, bus.alu_no};
                hi_pend      <= mul_p2;
            end else if (vld_p2) begin
                illegal_op <= 1'b1;
            end
        end
    end

    assign busy = vld_p1 || vld_p2 || hi_pend;
endmodule

// File: tb/tb_alu_wb.sv
// Scoreboard bench for alu_wb: a mock 2-cycle ALU returns hand-computed results; a monitor checks RF writes and illegal pulses.
module tb_alu_wb;
    localparam int RF_AW = 4;

    typedef struct packed {
        logic [15:0] d;
        logic        co;
        logic        zo;
        logic        no;
    } resp_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  a;
        logic [7:0]  d;
        logic [2:0]  s;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sreg;
    logic       illegal_op;
    logic       busy;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    wr_t   wr_q[$];
    wr_t   ill_q[$];
    resp_t drv_resp = '0;
    logic  drv_fire = 1'b0;
    resp_t resp_a   = '0;
    resp_t resp_b   = '0;
    logic  ci;

    always #5 clk = ~clk;

    alu_wb_if #(.RF_AW(RF_AW)) bus();

    alu_wb #(
        .RF_AW(RF_AW),
        .MUL_LO_ADDR(4'd0),
        .MUL_HI_ADDR(4'd1),
        .NOP_OPCODE(8'hF0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .sreg(sreg),
        .illegal_op(illegal_op),
        .busy(busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Mock ALU: result of an op fired in cycle c is presented during c+2
    always @(posedge clk) begin
        resp_a <= drv_fire ? drv_resp : '0;
        resp_b <= resp_a;
    end
    assign bus.alu_data = resp_b.d;
    assign bus.alu_co   = resp_b.co;
    assign bus.alu_zo   = resp_b.zo;
    assign bus.alu_no   = resp_b.no;

    function automatic resp_t mk(input logic [15:0] d, input logic co, input logic zo, input logic no);
        resp_t r;
        r.d = d; r.co = co; r.zo = zo; r.no = no;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write and illegal pulse must match the head of its queue
    always @(negedge clk) begin
        wr_t e;
        if (bus.rf_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h at cycle %0d, no write required",
                         bus.rf_waddr, bus.rf_wdata, cyc);
            end else begin
                e = wr_q.pop_front();
                check("wr_cycle", cyc, e.cyc);
                check("wr_addr", 32'(bus.rf_waddr), 32'(e.a));
                check("wr_data", 32'(bus.rf_wdata), 32'(e.d));
                check("wr_sreg", 32'(sreg), 32'(e.s));
            end
        end
        if (illegal_op === 1'b1) begin
            if (ill_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_illegal: pulse at cycle %0d, none required", cyc);
            end else begin
                e = ill_q.pop_front();
                check("ill_cycle", cyc, e.cyc);
                check("ill_sreg", 32'(sreg), 32'(e.s));
            end
        end
    end

    // kind: 0 normal write, 1 MULT (two writes), 2 illegal pulse, 3 no expectation
    task automatic issue(input logic [7:0] op, input logic [3:0] rd, input resp_t r, input bit use_ci,
                         input int kind, input logic [3:0] ea, input logic [15:0] ed, input logic [2:0] es,
                         input int exp_stall, output logic ci_at_fire);
        int  stalls = 0;
        wr_t e;
        bus.issue_valid  = 1'b1;
        bus.issue_opcode = op;
        bus.issue_rd     = rd;
        #1;
        while (bus.issue_ready !== 1'b1 && stalls < 10) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        ci_at_fire = bus.alu_ci;
        if (bus.issue_ready !== 1'b1) begin
            n_vec++;
            n_miss++;
            $display("FAIL issue_timeout: op 0x%0h ready=%b after %0d cycles, ready=1 required",
                     op, bus.issue_ready, stalls);
            bus.issue_valid = 1'b0;
            return;
        end
        check("stall_cycles", 32'(stalls), 32'(exp_stall));
        check("alu_opcode", 32'(bus.alu_opcode), 32'(op));
        drv_resp = r;
        if (use_ci) drv_resp.d = r.d + 16'(bus.alu_ci);
        drv_fire = 1'b1;
        case (kind)
            0: begin
                e = '{cyc: 32'(cyc + 3), a: ea, d: ed[7:0], s: es};
                wr_q.push_back(e);
            end
            1: begin
                e = '{cyc: 32'(cyc + 3), a: 4'd0, d: ed[7:0], s: es};
                wr_q.push_back(e);
                e = '{cyc: 32'(cyc + 4), a: 4'd1, d: ed[15:8], s: es};
                wr_q.push_back(e);
            end
            2: begin
                e = '{cyc: 32'(cyc + 3), a: 4'd0, d: 8'd0, s: es};
                ill_q.push_back(e);
            end
            default: ;
        endcase
        @(negedge clk);
        bus.issue_valid = 1'b0;
        drv_fire        = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        rst              = 1'b1;
        bus.issue_valid  = 1'b0;
        bus.issue_opcode = 8'h00;
        bus.issue_rd     = 4'd0;
        repeat (3) @(negedge clk);

        check("rst_rf_we", 32'(bus.rf_we), 32'd0);
        check("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        check("rst_rf_wdata", 32'(bus.rf_wdata), 32'd0);
        check("rst_sreg", 32'(sreg), 32'd0);
        check("rst_illegal_op", 32'(illegal_op), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_ci", 32'(bus.alu_ci), 32'd0);
        check("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
        check("rst_alu_opcode", 32'(bus.alu_opcode), 32'hF0);
        rst = 1'b0;
        @(negedge clk);

        // ADD 0x7F+0x01 -> 0x80, N set
        issue(8'h40, 4'd3, mk(16'h0080, 1'b0, 1'b0, 1'b1), 1'b0, 0, 4'd3, 16'h0080, 3'b001, 0, ci);
        repeat (6) @(negedge clk);

        // MULT 0xFF*0xFF = 0xFE01, N held at 1; following AND blocked one cycle
        issue(8'h30, 4'd7, mk(16'hFE01, 1'b1, 1'b0, 1'b1), 1'b0, 1, 4'd0, 16'hFE01, 3'b101, 0, ci);
        issue(8'h00, 4'd2, mk(16'h0055, 1'b0, 1'b0, 1'b0), 1'b0, 0, 4'd2, 16'h0055, 3'b000, 1, ci);
        repeat (6) @(negedge clk);

        // ADD 0xFF+0x01 sets C,Z; ADDC 0x00+0x00 must see carry-in 1
        issue(8'h40, 4'd4, mk(16'h0000, 1'b1, 1'b1, 1'b0), 1'b0, 0, 4'd4, 16'h0000, 3'b110, 0, ci);
`ifdef ALU_WB_CARRY_FWD_EN
        issue(8'h50, 4'd5, mk(16'h0000, 1'b0, 1'b0, 1'b0), 1'b1, 0, 4'd5, 16'h0001, 3'b000, 1, ci);
`else
        issue(8'h50, 4'd5, mk(16'h0000, 1'b0, 1'b0, 1'b0), 1'b1, 0, 4'd5, 16'h0001, 3'b000, 2, ci);
`endif
        check("addc_alu_ci", 32'(ci), 32'd1);
        repeat (6) @(negedge clk);

        // Illegal opcode: pulse only, flags from the ALU are ignored
        issue(8'hA0, 4'd6, mk(16'h00AA, 1'b1, 1'b1, 1'b1), 1'b0, 2, 4'd0, 16'h0000, 3'b000, 0, ci);
        repeat (6) @(negedge clk);

        // Back-to-back AND/OR/XOR
        for (int i = 0; i < 8; i++) begin
            d = 8'h11 * 8'(i + 1);
            issue(8'((i % 3) << 4), 4'(8 + i), mk({8'h00, d}, 1'b0, 1'b0, d[7]), 1'b0, 0,
                  4'(8 + i), {8'h00, d}, {2'b00, d[7]}, 0, ci);
        end
        repeat (6) @(negedge clk);

        // Reset in cycle c+2 of a MULT discards both of its writes
        issue(8'h40, 4'd2, mk(16'h0000, 1'b1, 1'b1, 1'b0), 1'b0, 0, 4'd2, 16'h0000, 3'b110, 0, ci);
        repeat (6) @(negedge clk);
        issue(8'h30, 4'd0, mk(16'hFE01, 1'b1, 1'b0, 1'b0), 1'b0, 3, 4'd0, 16'h0000, 3'b000, 0, ci);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_sreg", 32'(sreg), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_rf_we", 32'(bus.rf_we), 32'd0);

        check("pending_writes", 32'(wr_q.size()), 32'd0);
        check("pending_illegal", 32'(ill_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, completion required", $time);
        $fatal(1);
    end
endmodule
